// File: rtl/click_detector_if.sv
// Press-strobe input and click-event outputs of the click detector.
// The producer of the strobe takes the master side; the detector takes the slave side.
interface click_detector_if #(
    parameter int MAX_CLICKS = 3
) ();
    localparam int CW = $clog2(MAX_CLICKS + 1);

    logic          key_pressed_stb_i;
    logic [CW-1:0] click_cnt_o;
    logic          click_valid_o;
    logic          busy_o;

    modport master (
        output key_pressed_stb_i,
        input  click_cnt_o,
        input  click_valid_o,
        input  busy_o
    );

    modport slave (
        input  key_pressed_stb_i,
        output click_cnt_o,
        output click_valid_o,
        output busy_o
    );
endinterface

// File: rtl/click_detector.sv
// Groups debounced key-press strobes that arrive within a window into one click event
// and reports the number of presses in the group.
module click_detector #(
    parameter int CLK_FREQ_MHZ = 150,
    parameter int WINDOW_US    = 300000,
    parameter int MAX_CLICKS   = 3
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    click_detector_if.slave  bus
);
    localparam int WINDOW_CYC = CLK_FREQ_MHZ * WINDOW_US;
    localparam int TW         = $clog2(WINDOW_CYC);
    localparam int CW         = $clog2(MAX_CLICKS + 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] click_cnt_q, click_cnt_d;
    logic          click_valid_q, click_valid_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timer_d       = timer_q;
        click_cnt_d   = click_cnt_q;
        click_valid_d = 1'b0;
        busy_d        = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.key_pressed_stb_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = CW'(1);
                    timer_d = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                // A strobe always beats a simultaneous window expiry.
                if (bus.key_pressed_stb_i) begin
                    if (cnt_q + CW'(1) == CW'(MAX_CLICKS)) begin
                        click_cnt_d   = CW'(MAX_CLICKS);
                        click_valid_d = 1'b1;
                        state_d       = ST_IDLE;
                        cnt_d         = '0;
                        timer_d       = '0;
                        busy_d        = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        timer_d = '0;
                    end
                end else if (timer_q == TW'(WINDOW_CYC - 1)) begin
                    click_cnt_d   = cnt_q;
                    click_valid_d = 1'b1;
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    timer_d       = '0;
                    busy_d        = 1'b0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                timer_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            timer_q       <= '0;
            click_cnt_q   <= '0;
            click_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
            click_cnt_q   <= click_cnt_d;
            click_valid_q <= click_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.click_cnt_o   = click_cnt_q;
    assign bus.click_valid_o = click_valid_q;
    assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_click_detector.sv
// Directed bench for click_detector with WINDOW_CYC=10, MAX_CLICKS=3.
// Edge k of a case is the k-th rising edge; a strobe "at edge k" is the one sampled there.
module tb_click_detector;
    logic clk;
    logic arstn;
    int   n_cmp;
    int   n_err;

    click_detector_if #(.MAX_CLICKS(3)) bus_if ();

    click_detector #(
        .CLK_FREQ_MHZ(1),
        .WINDOW_US   (10),
        .MAX_CLICKS  (3)
    ) dut (
        .clk_i  (clk),
        .arstn_i(arstn),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drives strobes from mask over 40 edges and checks the emitted events.
    task automatic run_case(input string tag, input logic [39:0] mask,
                            input int exp_n, input int e0, input int c0,
                            input int e1, input int c1,
                            output logic [39:0] busy_v);
        int   n;
        int   ev_e[2];
        int   ev_c[2];
        logic prev_v;
        n      = 0;
        prev_v = 1'b0;
        ev_e   = '{-1, -1};
        ev_c   = '{-1, -1};
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus_if.key_pressed_stb_i = mask[k];
            @(posedge clk);
            #1;
            busy_v[k] = bus_if.busy_o;
            if (bus_if.click_valid_o) begin
                chk({tag, " back2back_valid"}, int'(prev_v), 0);
                chk({tag, " cnt_nonzero"}, int'(bus_if.click_cnt_o != 0), 1);
                if (n < 2) begin
                    ev_e[n] = k;
                    ev_c[n] = int'(bus_if.click_cnt_o);
                end
                n++;
            end
            prev_v = bus_if.click_valid_o;
        end
        bus_if.key_pressed_stb_i = 1'b0;
        $display("case %s: %0d event(s), first at edge %0d cnt %0d", tag, n, ev_e[0], ev_c[0]);
        chk({tag, " events"}, n, exp_n);
        if (exp_n >= 1) begin
            chk({tag, " ev0_edge"}, ev_e[0], e0);
            chk({tag, " ev0_cnt"}, ev_c[0], c0);
        end
        if (exp_n >= 2) begin
            chk({tag, " ev1_edge"}, ev_e[1], e1);
            chk({tag, " ev1_cnt"}, ev_c[1], c1);
        end
        if (exp_n >= 1)
            chk({tag, " cnt_held"}, int'(bus_if.click_cnt_o), (exp_n >= 2) ? c1 : c0);
        chk({tag, " busy_end"}, int'(bus_if.busy_o), 0);
    endtask

    localparam logic [39:0] ONE = 40'd1;

    initial begin
        logic [39:0] bv;
        n_cmp = 0;
        n_err = 0;
        arstn = 1'b0;
        bus_if.key_pressed_stb_i = 1'b0;
        #12;
        chk("reset cnt", int'(bus_if.click_cnt_o), 0);
        chk("reset valid", int'(bus_if.click_valid_o), 0);
        chk("reset busy", int'(bus_if.busy_o), 0);
        @(negedge clk);
        arstn = 1'b1;

        run_case("single", ONE << 0, 1, 10, 1, 0, 0, bv);
        chk("single busy@0", int'(bv[0]), 1);
        chk("single busy@9", int'(bv[9]), 1);
        chk("single busy@10", int'(bv[10]), 0);

        run_case("double", (ONE << 0) | (ONE << 7), 1, 17, 2, 0, 0, bv);
        chk("double busy@10", int'(bv[10]), 1);

        run_case("saturate", (ONE << 0) | (ONE << 3) | (ONE << 6) | (ONE << 8),
                 2, 6, 3, 18, 1, bv);
        chk("saturate busy@6", int'(bv[6]), 0);
        chk("saturate busy@8", int'(bv[8]), 1);

        run_case("edge9", (ONE << 0) | (ONE << 9), 1, 19, 2, 0, 0, bv);
        // Strobe on the expiry edge (timer at WINDOW_CYC-1) is counted instead.
        run_case("tie_expiry", (ONE << 0) | (ONE << 10), 1, 20, 2, 0, 0, bv);
        run_case("tie_saturate", (ONE << 0) | (ONE << 10) | (ONE << 20), 1, 20, 3, 0, 0, bv);
        // Second strobe is sampled while click_valid_o is high.
        run_case("back2back", (ONE << 0) | (ONE << 11), 2, 10, 1, 21, 1, bv);

        // Reset in the middle of an open group.
        @(negedge clk);
        bus_if.key_pressed_stb_i = 1'b1;
        @(negedge clk);
        bus_if.key_pressed_stb_i = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("pre-reset busy", int'(bus_if.busy_o), 1);
        arstn = 1'b0;
        #1;
        chk("async reset busy", int'(bus_if.busy_o), 0);
        chk("async reset cnt", int'(bus_if.click_cnt_o), 0);
        chk("async reset valid", int'(bus_if.click_valid_o), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
        run_case("after_reset_quiet", '0, 0, 0, 0, 0, 0, bv);
        chk("after_reset cnt", int'(bus_if.click_cnt_o), 0);
        run_case("fresh_single", ONE << 2, 1, 12, 1, 0, 0, bv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
